// File: rtl/irq_wfi_controller.sv
// Interrupt / WFI / MRET sequencer beside EX: latches interrupt sources, stalls on WFI,
// and requests PC redirects for trap entry and MRET return while capturing mepc/mcause.
module irq_wfi_controller #(
    parameter int unsigned        NUM_IRQ     = 4,
    parameter int unsigned        DATA_W      = 32,
    parameter logic [NUM_IRQ-1:0] IRQ_EDGE    = '0,
    parameter logic [DATA_W-1:0]  TRAP_VEC    = DATA_W'(32'h0001_0000),
    parameter int unsigned        MCAUSE_BASE = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic [NUM_IRQ-1:0] irq_en_i,
    input  logic [NUM_IRQ-1:0] irq_clear_i,
    input  logic               mie_global_i,
    input  logic               wfi_i,
    input  logic               mret_i,
    input  logic [DATA_W-1:0]  pc_i,
    input  logic               redirect_ack_i,
    output logic               wfi_stall_o,
    output logic               redirect_req_o,
    output logic [DATA_W-1:0]  redirect_pc_o,
    output logic               in_handler_o,
    output logic [DATA_W-1:0]  mepc_o,
    output logic [DATA_W-1:0]  mcause_o,
    output logic [NUM_IRQ-1:0] irq_pending_o
);

    localparam int unsigned IDX_W = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WFI,
        S_TRAP,
        S_HANDLER,
        S_MRET
    } state_e;

    state_e              state_q;
    state_e              state_d;
    logic [NUM_IRQ-1:0]  irq_q;
    logic [NUM_IRQ-1:0]  pend_q;
    logic [NUM_IRQ-1:0]  pend_d;
    logic [NUM_IRQ-1:0]  act;
    logic                any_act;
    logic [IDX_W-1:0]    win_idx;
    logic [DATA_W-1:0]   cause_val;
    logic [DATA_W-1:0]   wpc_q;
    logic [DATA_W-1:0]   wpc_d;
    logic [DATA_W-1:0]   mepc_d;
    logic [DATA_W-1:0]   mcause_d;
    logic                stall_d;
    logic                req_d;
    logic [DATA_W-1:0]   rpc_d;
    logic                in_handler_d;

    // Pending vector: level sources follow the pin, edge sources are sticky until W1C (set wins)
    always_comb begin
        pend_d = '0;
        for (int i = 0; i < int'(NUM_IRQ); i++) begin
            if (IRQ_EDGE[i]) begin
                pend_d[i] = (irq_i[i] & ~irq_q[i]) | (pend_q[i] & ~irq_clear_i[i]);
            end else begin
                pend_d[i] = irq_i[i];
            end
        end
    end

    assign act     = pend_q & irq_en_i;
    assign any_act = |act;

    // Lowest enabled pending index wins
    always_comb begin
        win_idx = '0;
        for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
            if (act[i]) begin
                win_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        cause_val             = DATA_W'(MCAUSE_BASE + 32'(win_idx));
        cause_val[DATA_W-1]   = 1'b1;
    end

    // Next-state, capture registers and next-output decode
    always_comb begin
        state_d      = state_q;
        mepc_d       = mepc_o;
        mcause_d     = mcause_o;
        wpc_d        = wpc_q;

        case (state_q)
            S_IDLE: begin
                if (mie_global_i && any_act) begin
                    mepc_d   = pc_i;
                    mcause_d = cause_val;
                    state_d  = S_TRAP;
                end else if (wfi_i) begin
                    wpc_d    = pc_i + DATA_W'(4);
                    state_d  = S_WFI;
                end
            end
            S_WFI: begin
                if (any_act) begin
                    if (mie_global_i) begin
                        mepc_d   = wpc_q;
                        mcause_d = cause_val;
                        state_d  = S_TRAP;
                    end else begin
                        state_d  = S_IDLE;
                    end
                end
            end
            S_TRAP: begin
                if (redirect_ack_i) begin
                    state_d = S_HANDLER;
                end
            end
            S_HANDLER: begin
                if (mret_i) begin
                    state_d = S_MRET;
                end
            end
            S_MRET: begin
                if (redirect_ack_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        stall_d      = (state_d == S_WFI);
        req_d        = (state_d == S_TRAP) || (state_d == S_MRET);
        in_handler_d = (state_d == S_HANDLER) || (state_d == S_MRET);
        rpc_d        = '0;
        if (state_d == S_TRAP) begin
            rpc_d = TRAP_VEC;
        end else if (state_d == S_MRET) begin
            rpc_d = mepc_d;
        end
    end

    // Outputs are loaded from the next-state decode so they track the state register exactly
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            irq_q          <= '0;
            pend_q         <= '0;
            wpc_q          <= '0;
            mepc_o         <= '0;
            mcause_o       <= '0;
            wfi_stall_o    <= 1'b0;
            redirect_req_o <= 1'b0;
            redirect_pc_o  <= '0;
            in_handler_o   <= 1'b0;
        end else begin
            state_q        <= state_d;
            irq_q          <= irq_i;
            pend_q         <= pend_d;
            wpc_q          <= wpc_d;
            mepc_o         <= mepc_d;
            mcause_o       <= mcause_d;
            wfi_stall_o    <= stall_d;
            redirect_req_o <= req_d;
            redirect_pc_o  <= rpc_d;
            in_handler_o   <= in_handler_d;
        end
    end

    assign irq_pending_o = pend_q;

endmodule

// File: tb/tb_irq_wfi_controller.sv
// Directed bench for irq_wfi_controller: trap entry, priority, WFI wake/resume, edge sources, MRET, reset.
module tb_irq_wfi_controller;

    logic        clk;
    logic        rst;
    logic [3:0]  irq_i;
    logic [3:0]  irq_en_i;
    logic [3:0]  irq_clear_i;
    logic        mie_global_i;
    logic        wfi_i;
    logic        mret_i;
    logic [31:0] pc_i;
    logic        redirect_ack_i;
    logic        wfi_stall_o;
    logic        redirect_req_o;
    logic [31:0] redirect_pc_o;
    logic        in_handler_o;
    logic [31:0] mepc_o;
    logic [31:0] mcause_o;
    logic [3:0]  irq_pending_o;

    int checks = 0;
    int errors = 0;

    irq_wfi_controller #(
        .NUM_IRQ    (4),
        .DATA_W     (32),
        .IRQ_EDGE   (4'b0001),
        .TRAP_VEC   (32'h0001_0000),
        .MCAUSE_BASE(16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .irq_i         (irq_i),
        .irq_en_i      (irq_en_i),
        .irq_clear_i   (irq_clear_i),
        .mie_global_i  (mie_global_i),
        .wfi_i         (wfi_i),
        .mret_i        (mret_i),
        .pc_i          (pc_i),
        .redirect_ack_i(redirect_ack_i),
        .wfi_stall_o   (wfi_stall_o),
        .redirect_req_o(redirect_req_o),
        .redirect_pc_o (redirect_pc_o),
        .in_handler_o  (in_handler_o),
        .mepc_o        (mepc_o),
        .mcause_o      (mcause_o),
        .irq_pending_o (irq_pending_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One active edge, then settle at the falling edge where inputs are driven and outputs sampled
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // From TRAP: ack, WFI as NOP in handler, MRET, ack back to IDLE
    task automatic run_handler(input logic [31:0] exp_mepc, input string tag);
        redirect_ack_i = 1'b1; irq_clear_i = 4'hF;
        step();
        redirect_ack_i = 1'b0;
        checks++; if (in_handler_o !== 1'b1) begin errors++; $display("FAIL %s_hdl_in got %0b exp 1", tag, in_handler_o); end
        checks++; if (redirect_req_o !== 1'b0) begin errors++; $display("FAIL %s_hdl_req got %0b exp 0", tag, redirect_req_o); end
        wfi_i = 1'b1;
        step();
        wfi_i = 1'b0; irq_clear_i = 4'h0;
        checks++; if (wfi_stall_o !== 1'b0 || in_handler_o !== 1'b1) begin errors++; $display("FAIL %s_hdl_wfi stall %0b in %0b exp 0 1", tag, wfi_stall_o, in_handler_o); end
        checks++; if (irq_pending_o !== 4'h0) begin errors++; $display("FAIL %s_hdl_pend got %h exp 0", tag, irq_pending_o); end
        mret_i = 1'b1;
        step();
        mret_i = 1'b0;
        checks++; if (redirect_req_o !== 1'b1) begin errors++; $display("FAIL %s_mret_req got %0b exp 1", tag, redirect_req_o); end
        checks++; if (redirect_pc_o !== exp_mepc) begin errors++; $display("FAIL %s_mret_pc got %h exp %h", tag, redirect_pc_o, exp_mepc); end
        checks++; if (in_handler_o !== 1'b1) begin errors++; $display("FAIL %s_mret_in got %0b exp 1", tag, in_handler_o); end
        redirect_ack_i = 1'b1;
        step();
        redirect_ack_i = 1'b0;
        checks++; if (redirect_req_o !== 1'b0 || in_handler_o !== 1'b0) begin errors++; $display("FAIL %s_ret req %0b in %0b exp 0 0", tag, redirect_req_o, in_handler_o); end
        checks++; if (mepc_o !== exp_mepc) begin errors++; $display("FAIL %s_ret_mepc got %h exp %h", tag, mepc_o, exp_mepc); end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        step();
        checks++; if (wfi_stall_o !== 1'b0) begin errors++; $display("FAIL rst_stall got %0b exp 0", wfi_stall_o); end
        checks++; if (redirect_req_o !== 1'b0) begin errors++; $display("FAIL rst_req got %0b exp 0", redirect_req_o); end
        checks++; if (redirect_pc_o !== 32'h0) begin errors++; $display("FAIL rst_rpc got %h exp 0", redirect_pc_o); end
        checks++; if (in_handler_o !== 1'b0) begin errors++; $display("FAIL rst_in got %0b exp 0", in_handler_o); end
        checks++; if (mepc_o !== 32'h0) begin errors++; $display("FAIL rst_mepc got %h exp 0", mepc_o); end
        checks++; if (mcause_o !== 32'h0) begin errors++; $display("FAIL rst_mcause got %h exp 0", mcause_o); end
        checks++; if (irq_pending_o !== 4'h0) begin errors++; $display("FAIL rst_pend got %h exp 0", irq_pending_o); end
        rst = 1'b1;
        redirect_ack_i = 1'b1; mret_i = 1'b1;
        step();
        redirect_ack_i = 1'b0; mret_i = 1'b0;
        checks++; if (redirect_req_o !== 1'b0 || in_handler_o !== 1'b0) begin errors++; $display("FAIL idle_ack_mret req %0b in %0b exp 0 0", redirect_req_o, in_handler_o); end
    endtask

    task automatic test_level();
        irq_i = 4'b0100; irq_en_i = 4'hF; mie_global_i = 1'b1; pc_i = 32'h100;
        step();
        checks++; if (irq_pending_o !== 4'b0100 || redirect_req_o !== 1'b0) begin errors++; $display("FAIL lvl_n1 pend %h req %0b exp 4 0", irq_pending_o, redirect_req_o); end
        step();
        checks++; if (redirect_req_o !== 1'b1) begin errors++; $display("FAIL lvl_req got %0b exp 1", redirect_req_o); end
        checks++; if (redirect_pc_o !== 32'h0001_0000) begin errors++; $display("FAIL lvl_rpc got %h exp 00010000", redirect_pc_o); end
        checks++; if (mepc_o !== 32'h100) begin errors++; $display("FAIL lvl_mepc got %h exp 100", mepc_o); end
        checks++; if (mcause_o !== 32'h8000_0012) begin errors++; $display("FAIL lvl_mcause got %h exp 80000012", mcause_o); end
        irq_i = 4'b0000; pc_i = 32'h0001_0000;
        step();
        step();
        checks++; if (redirect_req_o !== 1'b1 || redirect_pc_o !== 32'h0001_0000) begin errors++; $display("FAIL lvl_hold req %0b pc %h exp 1 00010000", redirect_req_o, redirect_pc_o); end
        run_handler(32'h100, "lvl");
    endtask

    task automatic test_priority();
        irq_i = 4'b1010; pc_i = 32'h300;
        step();
        step();
        checks++; if (redirect_req_o !== 1'b1) begin errors++; $display("FAIL pri_req got %0b exp 1", redirect_req_o); end
        checks++; if (mcause_o !== 32'h8000_0011) begin errors++; $display("FAIL pri_mcause got %h exp 80000011", mcause_o); end
        checks++; if (mepc_o !== 32'h300) begin errors++; $display("FAIL pri_mepc got %h exp 300", mepc_o); end
        irq_i = 4'b0000;
        run_handler(32'h300, "pri");
    endtask

    task automatic test_enable_mask();
        irq_en_i = 4'b1011; irq_i = 4'b0100;
        step();
        step();
        step();
        checks++; if (redirect_req_o !== 1'b0 || irq_pending_o !== 4'b0100) begin errors++; $display("FAIL mask req %0b pend %h exp 0 4", redirect_req_o, irq_pending_o); end
        irq_i = 4'b0000;
        step();
        irq_en_i = 4'hF;
        checks++; if (irq_pending_o !== 4'h0) begin errors++; $display("FAIL mask_drop got %h exp 0", irq_pending_o); end
    endtask

    task automatic test_wfi_wake();
        int bad = 0;
        pc_i = 32'h200; wfi_i = 1'b1;
        step();
        wfi_i = 1'b0; pc_i = 32'h999;
        checks++; if (wfi_stall_o !== 1'b1) begin errors++; $display("FAIL wfi_enter got %0b exp 1", wfi_stall_o); end
        for (int i = 0; i < 20; i++) begin
            step();
            if (wfi_stall_o !== 1'b1 || redirect_req_o !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL wfi_hold bad_cycles %0d exp 0", bad); end
        irq_i = 4'b0001;
        step();
        checks++; if (wfi_stall_o !== 1'b1 || irq_pending_o !== 4'b0001) begin errors++; $display("FAIL wfi_pend stall %0b pend %h exp 1 1", wfi_stall_o, irq_pending_o); end
        step();
        checks++; if (wfi_stall_o !== 1'b0 || redirect_req_o !== 1'b1) begin errors++; $display("FAIL wfi_wake stall %0b req %0b exp 0 1", wfi_stall_o, redirect_req_o); end
        checks++; if (mepc_o !== 32'h204) begin errors++; $display("FAIL wfi_mepc got %h exp 204", mepc_o); end
        checks++; if (mcause_o !== 32'h8000_0010) begin errors++; $display("FAIL wfi_mcause got %h exp 80000010", mcause_o); end
        irq_i = 4'b0000;
        run_handler(32'h204, "wfi");
    endtask

    task automatic test_wfi_nomie();
        mie_global_i = 1'b0; pc_i = 32'h400; wfi_i = 1'b1;
        step();
        wfi_i = 1'b0; irq_i = 4'b1000;
        checks++; if (wfi_stall_o !== 1'b1) begin errors++; $display("FAIL nomie_enter got %0b exp 1", wfi_stall_o); end
        step();
        checks++; if (wfi_stall_o !== 1'b1) begin errors++; $display("FAIL nomie_pend got %0b exp 1", wfi_stall_o); end
        step();
        checks++; if (wfi_stall_o !== 1'b0 || redirect_req_o !== 1'b0) begin errors++; $display("FAIL nomie_resume stall %0b req %0b exp 0 0", wfi_stall_o, redirect_req_o); end
        step();
        checks++; if (redirect_req_o !== 1'b0 || mepc_o !== 32'h204) begin errors++; $display("FAIL nomie_idle req %0b mepc %h exp 0 204", redirect_req_o, mepc_o); end
        irq_i = 4'b0000;
        step();
        mie_global_i = 1'b1;
    endtask

    task automatic test_trap_over_wfi();
        irq_i = 4'b0100; pc_i = 32'h600;
        step();
        wfi_i = 1'b1; pc_i = 32'h604;
        step();
        wfi_i = 1'b0; irq_i = 4'b0000;
        checks++; if (wfi_stall_o !== 1'b0 || redirect_req_o !== 1'b1) begin errors++; $display("FAIL tow stall %0b req %0b exp 0 1", wfi_stall_o, redirect_req_o); end
        checks++; if (mepc_o !== 32'h604) begin errors++; $display("FAIL tow_mepc got %h exp 604", mepc_o); end
        run_handler(32'h604, "tow");
    endtask

    task automatic test_edge_mret();
        irq_i = 4'b0001; irq_clear_i = 4'b0001; pc_i = 32'h500;
        step();
        irq_i = 4'b0000; irq_clear_i = 4'b0000;
        checks++; if (irq_pending_o !== 4'b0001 || redirect_req_o !== 1'b0) begin errors++; $display("FAIL edge_setwins pend %h req %0b exp 1 0", irq_pending_o, redirect_req_o); end
        step();
        checks++; if (redirect_req_o !== 1'b1 || mepc_o !== 32'h500) begin errors++; $display("FAIL edge_trap req %0b mepc %h exp 1 500", redirect_req_o, mepc_o); end
        checks++; if (irq_pending_o !== 4'b0001) begin errors++; $display("FAIL edge_sticky got %h exp 1", irq_pending_o); end
        run_handler(32'h500, "edge");
    endtask

    task automatic test_reset_mid_trap();
        irq_i = 4'b0100; pc_i = 32'h700;
        step();
        step();
        checks++; if (redirect_req_o !== 1'b1) begin errors++; $display("FAIL rmt_req got %0b exp 1", redirect_req_o); end
        rst = 1'b0;
        step();
        checks++; if (redirect_req_o !== 1'b0 || redirect_pc_o !== 32'h0 || wfi_stall_o !== 1'b0 || in_handler_o !== 1'b0) begin errors++; $display("FAIL rmt_outs req %0b pc %h stall %0b in %0b exp 0 0 0 0", redirect_req_o, redirect_pc_o, wfi_stall_o, in_handler_o); end
        checks++; if (mepc_o !== 32'h0 || mcause_o !== 32'h0) begin errors++; $display("FAIL rmt_csr mepc %h mcause %h exp 0 0", mepc_o, mcause_o); end
        checks++; if (irq_pending_o !== 4'h0) begin errors++; $display("FAIL rmt_pend got %h exp 0", irq_pending_o); end
        irq_i = 4'b0000; rst = 1'b1;
        step();
        step();
        checks++; if (redirect_req_o !== 1'b0 || in_handler_o !== 1'b0) begin errors++; $display("FAIL rmt_idle req %0b in %0b exp 0 0", redirect_req_o, in_handler_o); end
    endtask

    initial begin
        rst = 1'b0; irq_i = '0; irq_en_i = '0; irq_clear_i = '0; mie_global_i = 1'b0;
        wfi_i = 1'b0; mret_i = 1'b0; pc_i = '0; redirect_ack_i = 1'b0;
        @(negedge clk);
        test_reset();
        test_level();
        test_priority();
        test_enable_mask();
        test_wfi_wake();
        test_wfi_nomie();
        test_trap_over_wfi();
        test_edge_mret();
        test_reset_mid_trap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
